// File: rtl/write_buffer_pkg.sv
// rtl/write_buffer_pkg.sv - shared widths and entry type for the cache write-through path
package write_buffer_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/write_buffer_match.sv
// rtl/write_buffer_match.sv - address compare over queued entries, youngest match wins
module write_buffer_match
    import write_buffer_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit SKIP_HEAD = 1'b0,
    localparam int PW       = $clog2(DEPTH)
) (
    input  wb_entry_t         entries [DEPTH],
    input  logic [PW-1:0]     head,
    input  logic [PW:0]       count,
    input  logic [ADDR_W-1:0] key,
    output logic              hit,
    output logic [PW-1:0]     index,
    output logic [DATA_W-1:0] data
);

    logic [PW-1:0] slot;

    // Walk from oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        data  = '0;
        slot  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PW'(k);
            if ((k >= (SKIP_HEAD ? 1 : 0)) && ((PW+1)'(k) < count) && (entries[slot].addr == key)) begin
                hit   = 1'b1;
                index = slot;
                data  = entries[slot].data;
            end
        end
    end

endmodule

// File: rtl/write_buffer.sv
// rtl/write_buffer.sv - circular write-through buffer with in-place merge and lookup forwarding
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   WrValid,
    input  logic [ADDR_W-1:0]      WrAddr,
    input  logic [DATA_W-1:0]      WrData,
    output logic                   WrReady,
    input  logic [ADDR_W-1:0]      LookupAddr,
    output logic                   LookupHit,
    output logic [DATA_W-1:0]      LookupData,
    output logic                   MemReq,
    output logic [ADDR_W-1:0]      MemAddr,
    output logic [DATA_W-1:0]      MemData,
    input  logic                   MemAck,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Empty
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t     entries [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count_q;

    logic              merge_hit;
    logic [PW-1:0]     merge_idx;
    logic [DATA_W-1:0] merge_data;
    logic [PW-1:0]     lookup_idx;
    logic              full;
    logic              accept;
    logic              append;
    logic              pop;
    logic              unused_match;

    // The head may be on the memory bus right now, so it is never a merge target.
    write_buffer_match #(.DEPTH(DEPTH), .SKIP_HEAD(1'b1)) u_merge (
        .entries (entries),
        .head    (head),
        .count   (count_q),
        .key     (WrAddr),
        .hit     (merge_hit),
        .index   (merge_idx),
        .data    (merge_data)
    );

    write_buffer_match #(.DEPTH(DEPTH), .SKIP_HEAD(1'b0)) u_lookup (
        .entries (entries),
        .head    (head),
        .count   (count_q),
        .key     (LookupAddr),
        .hit     (LookupHit),
        .index   (lookup_idx),
        .data    (LookupData)
    );

    assign unused_match = ^{merge_data, lookup_idx};

    assign Empty   = (count_q == '0);
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign WrReady = !full || merge_hit;
    assign accept  = WrValid && WrReady;
    assign append  = accept && !merge_hit;
    assign pop     = !Empty && MemAck;

    assign Count   = count_q;
    assign MemReq  = !Empty;
    assign MemAddr = Empty ? '0 : entries[head].addr;
    assign MemData = Empty ? '0 : entries[head].data;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (accept && merge_hit) begin
                entries[merge_idx].data <= WrData;
            end
            if (append) begin
                entries[tail] <= '{addr: WrAddr, data: WrData};
                tail          <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count_q <= count_q + (PW+1)'(append) - (PW+1)'(pop);
        end
    end

endmodule

// File: tb/tb_write_buffer.sv
// tb/tb_write_buffer.sv - scoreboard bench for write_buffer
module tb_write_buffer;
    import write_buffer_pkg::*;

    logic              Clock;
    logic              Reset;
    logic              WrValid;
    logic [ADDR_W-1:0] WrAddr;
    logic [DATA_W-1:0] WrData;
    logic              WrReady;
    logic [ADDR_W-1:0] LookupAddr;
    logic              LookupHit;
    logic [DATA_W-1:0] LookupData;
    logic              MemReq;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemData;
    logic              MemAck;
    logic [2:0]        Count;
    logic              Empty;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    int mem_model [32];
    wb_entry_t sb [$];

    write_buffer #(.DEPTH(4)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .WrValid    (WrValid),
        .WrAddr     (WrAddr),
        .WrData     (WrData),
        .WrReady    (WrReady),
        .LookupAddr (LookupAddr),
        .LookupHit  (LookupHit),
        .LookupData (LookupData),
        .MemReq     (MemReq),
        .MemAddr    (MemAddr),
        .MemData    (MemData),
        .MemAck     (MemAck),
        .Count      (Count),
        .Empty      (Empty)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Called at a negedge: drives one cycle, scores the drain, advances the model.
    task automatic drive(input logic wv, input logic [4:0] wa, input logic [4:0] wd, input logic ack);
        int  mi;
        bit  room;
        bit  had;
        WrValid = wv;
        WrAddr  = wa;
        WrData  = wd;
        MemAck  = ack;
        #1;
        mi = -1;
        for (int i = 1; i < sb.size(); i++) if (sb[i].addr == wa) mi = i;
        room = (sb.size() < 4) || (mi >= 0);
        had  = (sb.size() > 0);
        total++;
        if (WrReady !== room) begin
            bad++;
            $display("FAIL wrready addr=%0d got=%b want=%b", wa, WrReady, room);
        end
        if (ack) begin
            total++;
            if (MemReq !== had) begin
                bad++;
                $display("FAIL memreq got=%b want=%b", MemReq, had);
            end else if (had) begin
                if (MemAddr !== sb[0].addr || MemData !== sb[0].data) begin
                    bad++;
                    $display("FAIL drain got=(%0d,%0d) want=(%0d,%0d)", MemAddr, MemData, sb[0].addr, sb[0].data);
                end
            end
            if (MemReq === 1'b1) begin
                mem_model[MemAddr] = int'(MemData);
                pops++;
            end
        end
        @(posedge Clock);
        if (wv && room) begin
            if (mi >= 0) sb[mi].data = wd;
            else sb.push_back('{addr: wa, data: wd});
        end
        if (ack && had) void'(sb.pop_front());
        @(negedge Clock);
        WrValid = 1'b0;
        MemAck  = 1'b0;
    endtask

    task automatic drain_all();
        for (int i = 0; i < 8 && sb.size() > 0; i++) drive(1'b0, 5'd0, 5'd0, 1'b1);
        total++;
        if (Empty !== 1'b1) begin
            bad++;
            $display("FAIL drain_empty got=%b want=1", Empty);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        WrValid = 1'b0; WrAddr = '0; WrData = '0; MemAck = 1'b0; LookupAddr = '0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        sb.delete();
        #1;
        total++;
        if (Count !== 3'd0 || Empty !== 1'b1 || WrReady !== 1'b1 || MemReq !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl count=%0d empty=%b wrready=%b memreq=%b want 0,1,1,0", Count, Empty, WrReady, MemReq);
        end
        total++;
        if (MemAddr !== 5'd0 || MemData !== 5'd0 || LookupHit !== 1'b0 || LookupData !== 5'd0) begin
            bad++;
            $display("FAIL reset_data memaddr=%0d memdata=%0d hit=%b ldata=%0d want all 0", MemAddr, MemData, LookupHit, LookupData);
        end
        @(negedge Clock);
    endtask

    task automatic test_drain();
        drive(1'b1, 5'd3, 5'd7, 1'b0);
        drive(1'b1, 5'd9, 5'd2, 1'b0);
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 5'd0, 5'd0, 1'b0);
            total++;
            if (Count !== 3'd2 || MemReq !== 1'b1 || MemAddr !== 5'd3 || MemData !== 5'd7) begin
                bad++;
                $display("FAIL drain_hold count=%0d req=%b head=(%0d,%0d) want 2,1,(3,7)", Count, MemReq, MemAddr, MemData);
            end
        end
        drive(1'b0, 5'd0, 5'd0, 1'b1);
        total++;
        if (Count !== 3'd1 || MemAddr !== 5'd9 || MemData !== 5'd2) begin
            bad++;
            $display("FAIL drain_pop count=%0d head=(%0d,%0d) want 1,(9,2)", Count, MemAddr, MemData);
        end
        drain_all();
    endtask

    task automatic test_merge();
        drive(1'b1, 5'd10, 5'd1, 1'b0);
        drive(1'b1, 5'd20, 5'd2, 1'b0);
        drive(1'b1, 5'd11, 5'd3, 1'b0);
        drive(1'b1, 5'd13, 5'd4, 1'b0);
        drive(1'b1, 5'd12, 5'd9, 1'b0);
        drive(1'b1, 5'd20, 5'd31, 1'b0);
        LookupAddr = 5'd20;
        #1;
        total++;
        if (Count !== 3'd4 || LookupHit !== 1'b1 || LookupData !== 5'd31) begin
            bad++;
            $display("FAIL merge count=%0d hit=%b data=%0d want 4,1,31", Count, LookupHit, LookupData);
        end
        LookupAddr = 5'd10;
        #1;
        total++;
        if (LookupHit !== 1'b1 || LookupData !== 5'd1) begin
            bad++;
            $display("FAIL lookup_head hit=%b data=%0d want 1,1", LookupHit, LookupData);
        end
        LookupAddr = 5'd12;
        #1;
        total++;
        if (LookupHit !== 1'b0 || LookupData !== 5'd0) begin
            bad++;
            $display("FAIL lookup_miss hit=%b data=%0d want 0,0", LookupHit, LookupData);
        end
        drain_all();
    endtask

    task automatic test_head_no_merge();
        drive(1'b1, 5'd5, 5'd1, 1'b0);
        drive(1'b1, 5'd5, 5'd4, 1'b0);
        LookupAddr = 5'd5;
        #1;
        total++;
        if (Count !== 3'd2 || LookupHit !== 1'b1 || LookupData !== 5'd4) begin
            bad++;
            $display("FAIL head_append count=%0d hit=%b data=%0d want 2,1,4", Count, LookupHit, LookupData);
        end
        drain_all();
    endtask

    task automatic test_full_pop();
        for (int i = 1; i <= 4; i++) drive(1'b1, 5'(i), 5'(i + 16), 1'b0);
        drive(1'b1, 5'd7, 5'd7, 1'b1);
        total++;
        if (Count !== 3'd3) begin
            bad++;
            $display("FAIL full_pop count=%0d want 3", Count);
        end
        drive(1'b1, 5'd7, 5'd7, 1'b0);
        total++;
        if (Count !== 3'd4) begin
            bad++;
            $display("FAIL full_retry count=%0d want 4", Count);
        end
        drain_all();
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 3; i++) drive(1'b1, 5'(i), 5'(i), 1'b0);
        Reset = 1'b1; MemAck = 1'b1; WrValid = 1'b1; WrAddr = 5'd8; WrData = 5'd8;
        @(negedge Clock);
        Reset = 1'b0; MemAck = 1'b0; WrValid = 1'b0;
        sb.delete();
        LookupAddr = 5'd2;
        #1;
        total++;
        if (Count !== 3'd0 || Empty !== 1'b1 || MemReq !== 1'b0 || MemAddr !== 5'd0 || LookupHit !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid count=%0d empty=%b req=%b addr=%0d hit=%b want 0,1,0,0,0", Count, Empty, MemReq, MemAddr, LookupHit);
        end
        @(negedge Clock);
    endtask

    task automatic test_stream();
        int i = 0;
        int c = 0;
        int pops0;
        bit room;
        for (int k = 0; k < 32; k++) mem_model[k] = -1;
        pops0 = pops;
        while ((i < 32 || sb.size() > 0) && c < 400) begin
            room = (sb.size() < 4);
            if (i < 32) drive(1'b1, 5'(i), 5'(i), c[0]);
            else drive(1'b0, 5'd0, 5'd0, c[0]);
            if (i < 32 && room) i++;
            c++;
        end
        total++;
        if (c >= 400 || pops - pops0 != 32) begin
            bad++;
            $display("FAIL stream_done cycles=%0d pops=%0d want pops=32", c, pops - pops0);
        end
        for (int k = 0; k < 32; k++) begin
            total++;
            if (mem_model[k] != k) begin
                bad++;
                $display("FAIL stream_mem addr=%0d got=%0d want=%0d", k, mem_model[k], k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_drain();
        test_merge();
        test_head_no_merge();
        test_full_pop();
        test_reset_mid();
        test_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
